dtlb_buffer: RTL and testbench

Parametrised multi-entry data-side TLB buffer between the M1 stage and the shared main TLB. Caches ENTRIES full TLB pairs (VPN2/ASID/G plus even and odd PFN/C/D/V). A hit translates in the same cycle. A miss stalls M1 and runs a query/fill handshake against the main TLB. Raises refill, invalid and modified exceptions, and classifies accesses as uncached for the DCache.

---
 rtl/dtlb_buffer.sv | 210 +++++++++++++++++++++
 tb/tb_dtlb_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtlb_buffer.sv
// Data-side TLB buffer between M1 and the shared main TLB. Hits and unmapped accesses
// translate combinationally; a miss stalls M1 and runs a query/fill handshake.
`ifndef NO_EX
`define NO_EX              5'h1f
`endif
`ifndef DTLB_EX_Modified
`define DTLB_EX_Modified   5'h01
`endif
`ifndef DTLB_EX_RD_Refill
`define DTLB_EX_RD_Refill  5'h02
`endif
`ifndef DTLB_EX_WR_Refill
`define DTLB_EX_WR_Refill  5'h03
`endif
`ifndef DTLB_EX_RD_Invalid
`define DTLB_EX_RD_Invalid 5'h04
`endif
`ifndef DTLB_EX_WR_Invalid
`define DTLB_EX_WR_Invalid 5'h05
`endif

module dtlb_buffer #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [31:0] req_vaddr,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [7:0]  cur_asid,
    input  logic        flush,
    output logic        stall,
    output logic [19:0] paddr_tag,
    output logic        uncache,
    output logic        ex,
    output logic [4:0]  exctype,
    output logic        tlb_q_valid,
    output logic [18:0] tlb_q_vpn2,
    output logic [7:0]  tlb_q_asid,
    input  logic        tlb_r_valid,
    input  logic        tlb_r_found,
    input  logic [19:0] tlb_r_pfn0,
    input  logic [19:0] tlb_r_pfn1,
    input  logic [2:0]  tlb_r_c0,
    input  logic [2:0]  tlb_r_c1,
    input  logic        tlb_r_d0,
    input  logic        tlb_r_v0,
    input  logic        tlb_r_d1,
    input  logic        tlb_r_v1,
    input  logic        tlb_r_g
);

    typedef enum logic [1:0] {StIdle, StQuery, StMiss} state_e;

    state_e             state_q;
    logic [ENTRIES-1:0] valid_q;
    logic [IDX_W-1:0]   rr_q;
    logic [18:0]        q_vpn2_q;
    logic [7:0]         q_asid_q;

    logic [18:0]        vpn2_q [ENTRIES];
    logic [7:0]         asid_q [ENTRIES];
    logic [19:0]        pfn0_q [ENTRIES];
    logic [19:0]        pfn1_q [ENTRIES];
    logic [2:0]         c0_q   [ENTRIES];
    logic [2:0]         c1_q   [ENTRIES];
    logic [ENTRIES-1:0] g_q, d0_q, d1_q, v0_q, v1_q;

    logic               act, unmapped, hit, all_valid, miss_start, fill_en;
    logic [ENTRIES-1:0] hit_vec;
    logic [IDX_W-1:0]   hit_idx, victim_idx;
    logic [19:0]        sel_pfn;
    logic [2:0]         sel_c;
    logic               sel_d, sel_v;
    logic               unused_vaddr_lo;

    // Outputs stay quiet while reset is held, even with a request present.
    assign act       = resetn & req_valid & (req_load | req_store);
    assign unmapped  = (req_vaddr[31:30] == 2'b10);
    assign all_valid = &valid_q;
    assign unused_vaddr_lo = ^req_vaddr[11:0];

    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            hit_vec[i] = valid_q[i] && (vpn2_q[i] == req_vaddr[31:13]) &&
                         (g_q[i] || (asid_q[i] == cur_asid));
            if (hit_vec[i]) hit_idx = IDX_W'(i);
        end
    end
    assign hit = |hit_vec;

    // Lowest-index free slot wins; the round-robin pointer only matters when full.
    always_comb begin
        victim_idx = rr_q;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) victim_idx = IDX_W'(i);
        end
    end

    assign sel_pfn = req_vaddr[12] ? pfn1_q[hit_idx] : pfn0_q[hit_idx];
    assign sel_c   = req_vaddr[12] ? c1_q[hit_idx]   : c0_q[hit_idx];
    assign sel_d   = req_vaddr[12] ? d1_q[hit_idx]   : d0_q[hit_idx];
    assign sel_v   = req_vaddr[12] ? v1_q[hit_idx]   : v0_q[hit_idx];

    always_comb begin
        stall     = 1'b0;
        paddr_tag = '0;
        uncache   = 1'b0;
        ex        = 1'b0;
        exctype   = `NO_EX;
        if (unmapped) begin
            paddr_tag = {3'b000, req_vaddr[28:12]};
            uncache   = req_vaddr[29];
        end else if (hit) begin
            paddr_tag = sel_pfn;
            uncache   = (sel_c == 3'd2);
        end
        if (act) begin
            unique case (state_q)
                StIdle: begin
                    if (!unmapped) begin
                        if (!hit) begin
                            stall = 1'b1;
                        end else if (!sel_v) begin
                            ex      = 1'b1;
                            exctype = req_load ? `DTLB_EX_RD_Invalid : `DTLB_EX_WR_Invalid;
                        end else if (req_store && !sel_d) begin
                            ex      = 1'b1;
                            exctype = `DTLB_EX_Modified;
                        end
                    end
                end
                StQuery: stall = 1'b1;
                StMiss: begin
                    ex      = 1'b1;
                    exctype = req_load ? `DTLB_EX_RD_Refill : `DTLB_EX_WR_Refill;
                end
                default: ;
            endcase
        end
    end

    assign tlb_q_valid = (state_q == StQuery);
    assign tlb_q_vpn2  = q_vpn2_q;
    assign tlb_q_asid  = q_asid_q;

    assign miss_start = act & ~unmapped & ~hit & (state_q == StIdle);
    // A response coinciding with flush is dropped.
    assign fill_en    = (state_q == StQuery) & tlb_r_valid & tlb_r_found & ~flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            valid_q  <= '0;
            rr_q     <= '0;
            q_vpn2_q <= '0;
            q_asid_q <= '0;
        end else if (flush) begin
            state_q <= StIdle;
            valid_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (miss_start) begin
                        state_q  <= StQuery;
                        q_vpn2_q <= req_vaddr[31:13];
                        q_asid_q <= cur_asid;
                    end
                end
                StQuery: begin
                    if (tlb_r_valid) begin
                        if (tlb_r_found) begin
                            state_q             <= StIdle;
                            valid_q[victim_idx] <= 1'b1;
                            if (all_valid) rr_q <= rr_q + IDX_W'(1);
                        end else begin
                            state_q <= StMiss;
                        end
                    end
                end
                StMiss: begin
                    if (!act) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Payload needs no reset: valid_q gates every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            vpn2_q[victim_idx] <= q_vpn2_q;
            asid_q[victim_idx] <= q_asid_q;
            pfn0_q[victim_idx] <= tlb_r_pfn0;
            pfn1_q[victim_idx] <= tlb_r_pfn1;
            c0_q[victim_idx]   <= tlb_r_c0;
            c1_q[victim_idx]   <= tlb_r_c1;
            g_q[victim_idx]    <= tlb_r_g;
            d0_q[victim_idx]   <= tlb_r_d0;
            d1_q[victim_idx]   <= tlb_r_d1;
            v0_q[victim_idx]   <= tlb_r_v0;
            v1_q[victim_idx]   <= tlb_r_v1;
        end
    end

endmodule

// File: tb/tb_dtlb_buffer.sv
// Scoreboard bench for dtlb_buffer: stimulus queues expected outputs per cycle,
// a monitor pops and compares them on the falling clock edge.
module tb_dtlb_buffer;

    localparam logic [4:0] NO_EX     = 5'h1f;
    localparam logic [4:0] EX_MOD    = 5'h01;
    localparam logic [4:0] EX_RD_REF = 5'h02;
    localparam logic [4:0] EX_WR_REF = 5'h03;
    localparam logic [4:0] EX_RD_INV = 5'h04;
    localparam logic [4:0] EX_WR_INV = 5'h05;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_load, req_store, flush;
    logic [31:0] req_vaddr;
    logic [7:0]  cur_asid;
    logic        stall, uncache, ex, tlb_q_valid;
    logic [19:0] paddr_tag;
    logic [4:0]  exctype;
    logic [18:0] tlb_q_vpn2;
    logic [7:0]  tlb_q_asid;
    logic        tlb_r_valid, tlb_r_found, tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1, tlb_r_g;
    logic [19:0] tlb_r_pfn0, tlb_r_pfn1;
    logic [2:0]  tlb_r_c0, tlb_r_c1;

    dtlb_buffer #(.ENTRIES(4)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_vaddr(req_vaddr), .req_load(req_load),
        .req_store(req_store), .cur_asid(cur_asid), .flush(flush),
        .stall(stall), .paddr_tag(paddr_tag), .uncache(uncache), .ex(ex), .exctype(exctype),
        .tlb_q_valid(tlb_q_valid), .tlb_q_vpn2(tlb_q_vpn2), .tlb_q_asid(tlb_q_asid),
        .tlb_r_valid(tlb_r_valid), .tlb_r_found(tlb_r_found),
        .tlb_r_pfn0(tlb_r_pfn0), .tlb_r_pfn1(tlb_r_pfn1),
        .tlb_r_c0(tlb_r_c0), .tlb_r_c1(tlb_r_c1),
        .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0), .tlb_r_d1(tlb_r_d1), .tlb_r_v1(tlb_r_v1),
        .tlb_r_g(tlb_r_g)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic        ex;
        logic [4:0]  exc;
        logic        qv;
        bit          cpt;
        logic [19:0] ptag;
        logic        unc;
        bit          cq;
        logic [18:0] qvpn2;
        logic [7:0]  qasid;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s.%s got=%0h want=%0h t=%0t", nm, fld, got, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                cmp(e.name, "stall", 32'(stall), 32'(e.stall));
                cmp(e.name, "ex", 32'(ex), 32'(e.ex));
                cmp(e.name, "exctype", 32'(exctype), 32'(e.exc));
                cmp(e.name, "q_valid", 32'(tlb_q_valid), 32'(e.qv));
                if (e.cpt) begin
                    cmp(e.name, "paddr_tag", 32'(paddr_tag), 32'(e.ptag));
                    cmp(e.name, "uncache", 32'(uncache), 32'(e.unc));
                end
                if (e.cq) begin
                    cmp(e.name, "q_vpn2", 32'(tlb_q_vpn2), 32'(e.qvpn2));
                    cmp(e.name, "q_asid", 32'(tlb_q_asid), 32'(e.qasid));
                end
            end
        end
    end

    task automatic push(input string nm, input logic st, input logic x, input logic [4:0] xc,
                        input logic qv, input bit cpt, input logic [19:0] pt, input logic un,
                        input bit cq, input logic [18:0] vp, input logic [7:0] as);
        exp_t e;
        e.name = nm; e.stall = st; e.ex = x; e.exc = xc; e.qv = qv;
        e.cpt = cpt; e.ptag = pt; e.unc = un; e.cq = cq; e.qvpn2 = vp; e.qasid = as;
        sbq.push_back(e);
    endtask

    task automatic chk_pt(input string nm, input logic st, input logic x, input logic [4:0] xc,
                          input logic [19:0] pt, input logic un);
        push(nm, st, x, xc, 1'b0, 1'b1, pt, un, 1'b0, '0, '0);
    endtask

    task automatic chk_q(input string nm, input logic [18:0] vp, input logic [7:0] as);
        push(nm, 1'b1, 1'b0, NO_EX, 1'b1, 1'b0, '0, 1'b0, 1'b1, vp, as);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [31:0] va, input logic ld, input logic st,
                       input logic [7:0] as);
        req_valid = v; req_vaddr = va; req_load = ld; req_store = st; cur_asid = as;
    endtask

    task automatic rsp(input logic v, input logic fnd,
                       input logic [19:0] p0, input logic [2:0] c0, input logic d0, input logic v0,
                       input logic [19:0] p1, input logic [2:0] c1, input logic d1, input logic v1,
                       input logic g);
        tlb_r_valid = v; tlb_r_found = fnd; tlb_r_g = g;
        tlb_r_pfn0 = p0; tlb_r_c0 = c0; tlb_r_d0 = d0; tlb_r_v0 = v0;
        tlb_r_pfn1 = p1; tlb_r_c1 = c1; tlb_r_d1 = d1; tlb_r_v1 = v1;
    endtask

    task automatic fill(input string nm, input logic [31:0] va, input logic [19:0] pfn);
        req(1'b1, va, 1'b1, 1'b0, 8'h11);
        chk_pt({nm, "_miss"}, 1'b1, 1'b0, NO_EX, 20'h0, 1'b0);
        step();
        rsp(1'b1, 1'b1, pfn, 3'd3, 1'b1, 1'b1, pfn, 3'd3, 1'b1, 1'b1, 1'b1);
        chk_q({nm, "_q"}, va[31:13], 8'h11);
        step();
        tlb_r_valid = 1'b0;
        chk_pt({nm, "_hit"}, 1'b0, 1'b0, NO_EX, pfn, 1'b0);
        step();
    endtask

    task automatic hit(input string nm, input logic [31:0] va, input logic [19:0] pfn);
        req(1'b1, va, 1'b1, 1'b0, 8'h11);
        chk_pt(nm, 1'b0, 1'b0, NO_EX, pfn, 1'b0);
        step();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : stim
        resetn = 1'b0;
        flush  = 1'b0;
        req(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        rsp(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step();
        push("rst", 1'b0, 1'b0, NO_EX, 1'b0, 1'b1, 20'h0, 1'b0, 1'b1, '0, '0);
        step();
        resetn = 1'b1;
        push("rst_after", 1'b0, 1'b0, NO_EX, 1'b0, 1'b1, 20'h0, 1'b0, 1'b1, '0, '0);
        step();

        // Unmapped kseg1 / kseg0
        req(1'b1, 32'hA000_1234, 1'b1, 1'b0, 8'h00);
        chk_pt("unm_kseg1", 1'b0, 1'b0, NO_EX, 20'h00001, 1'b1);
        step();
        req(1'b1, 32'h8000_5000, 1'b1, 1'b0, 8'h00);
        chk_pt("unm_kseg0", 1'b0, 1'b0, NO_EX, 20'h00005, 1'b0);
        step();

        // Miss, fastest fill, then hits on both pages
        req(1'b1, 32'h0040_3000, 1'b1, 1'b0, 8'h05);
        chk_pt("m1_c0", 1'b1, 1'b0, NO_EX, 20'h0, 1'b0);
        step();
        rsp(1'b1, 1'b1, 20'h0AAAA, 3'd2, 1'b0, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1, 1'b0);
        chk_q("m1_c1", 19'h00201, 8'h05);
        step();
        tlb_r_valid = 1'b0;
        chk_pt("m1_c2", 1'b0, 1'b0, NO_EX, 20'h12345, 1'b0);
        step();
        chk_pt("m1_rep", 1'b0, 1'b0, NO_EX, 20'h12345, 1'b0);
        step();
        req(1'b1, 32'h0040_2000, 1'b1, 1'b0, 8'h05);
        chk_pt("even_unc", 1'b0, 1'b0, NO_EX, 20'h0AAAA, 1'b1);
        step();
        req(1'b1, 32'h0040_2000, 1'b0, 1'b1, 8'h05);
        chk_pt("modified", 1'b0, 1'b1, EX_MOD, 20'h0AAAA, 1'b1);
        step();
        req(1'b1, 32'h0040_3000, 1'b0, 1'b1, 8'h05);
        chk_pt("store_ok", 1'b0, 1'b0, NO_EX, 20'h12345, 1'b0);
        step();

        // ASID mismatch misses; global refill; vaddr change during QUERY ignored
        req(1'b1, 32'h0040_3000, 1'b1, 1'b0, 8'h06);
        chk_pt("asid_miss", 1'b1, 1'b0, NO_EX, 20'h0, 1'b0);
        step();
        req(1'b1, 32'h1234_5000, 1'b1, 1'b0, 8'h06);
        rsp(1'b1, 1'b1, 20'h33333, 3'd3, 1'b0, 1'b0, 20'h22222, 3'd3, 1'b1, 1'b1, 1'b1);
        chk_q("asid_q", 19'h00201, 8'h06);
        step();
        tlb_r_valid = 1'b0;
        req(1'b1, 32'h0040_3000, 1'b1, 1'b0, 8'h06);
        chk_pt("asid_hit", 1'b0, 1'b0, NO_EX, 20'h22222, 1'b0);
        step();
        req(1'b1, 32'h0040_3000, 1'b1, 1'b0, 8'h77);
        chk_pt("global_hit", 1'b0, 1'b0, NO_EX, 20'h22222, 1'b0);
        step();
        req(1'b1, 32'h0040_2000, 1'b1, 1'b0, 8'h77);
        chk_pt("rd_invalid", 1'b0, 1'b1, EX_RD_INV, 20'h33333, 1'b0);
        step();
        req(1'b1, 32'h0040_2000, 1'b0, 1'b1, 8'h77);
        chk_pt("wr_invalid", 1'b0, 1'b1, EX_WR_INV, 20'h33333, 1'b0);
        step();

        // Store refill held until flush
        req(1'b1, 32'h0100_0000, 1'b0, 1'b1, 8'h77);
        chk_pt("wr_ref_c0", 1'b1, 1'b0, NO_EX, 20'h0, 1'b0);
        step();
        rsp(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk_q("wr_ref_q", 19'h00800, 8'h77);
        step();
        tlb_r_valid = 1'b0;
        chk_pt("wr_ref_m", 1'b0, 1'b1, EX_WR_REF, 20'h0, 1'b0);
        step();
        chk_pt("wr_ref_hold", 1'b0, 1'b1, EX_WR_REF, 20'h0, 1'b0);
        step();
        flush = 1'b1;
        chk_pt("wr_ref_fl", 1'b0, 1'b1, EX_WR_REF, 20'h0, 1'b0);
        step();
        flush = 1'b0;
        req(1'b0, 32'h0100_0000, 1'b0, 1'b1, 8'h77);
        chk_pt("post_flush", 1'b0, 1'b0, NO_EX, 20'h0, 1'b0);
        step();

        // Flushed entry misses; load refill then idle on act=0
        req(1'b1, 32'h0040_3000, 1'b1, 1'b0, 8'h77);
        chk_pt("fl_inv", 1'b1, 1'b0, NO_EX, 20'h0, 1'b0);
        step();
        rsp(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk_q("fl_inv_q", 19'h00201, 8'h77);
        step();
        tlb_r_valid = 1'b0;
        chk_pt("rd_refill", 1'b0, 1'b1, EX_RD_REF, 20'h0, 1'b0);
        step();
        req(1'b0, 32'h0040_3000, 1'b1, 1'b0, 8'h77);
        chk_pt("rd_ref_exit", 1'b0, 1'b0, NO_EX, 20'h0, 1'b0);
        step();

        // Replacement: four fills, fifth evicts entry 0, rr then points at entry 1
        fill("fA", 32'h0001_0000, 20'h1000A);
        fill("fB", 32'h0002_0000, 20'h1000B);
        fill("fC", 32'h0003_0000, 20'h1000C);
        fill("fD", 32'h0004_0000, 20'h1000D);
        fill("fE", 32'h0005_0000, 20'h1000E);
        hit("hB", 32'h0002_0000, 20'h1000B);
        hit("hC", 32'h0003_0000, 20'h1000C);
        hit("hD", 32'h0004_0000, 20'h1000D);
        hit("hE", 32'h0005_0000, 20'h1000E);
        fill("fA2", 32'h0001_0000, 20'h1000F);
        hit("hC2", 32'h0003_0000, 20'h1000C);
        req(1'b1, 32'h0002_0000, 1'b1, 1'b0, 8'h11);
        chk_pt("B_evicted", 1'b1, 1'b0, NO_EX, 20'h0, 1'b0);
        step();
        rsp(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk_q("B_q", 19'h00010, 8'h11);
        step();
        tlb_r_valid = 1'b0;
        req(1'b0, 32'h0002_0000, 1'b1, 1'b0, 8'h11);
        chk_pt("B_idle", 1'b0, 1'b0, NO_EX, 20'h0, 1'b0);
        step();

        // Flush racing a found response: nothing written
        req(1'b1, 32'h0006_0000, 1'b1, 1'b0, 8'h11);
        chk_pt("fr_c0", 1'b1, 1'b0, NO_EX, 20'h0, 1'b0);
        step();
        rsp(1'b1, 1'b1, 20'h10066, 3'd3, 1'b1, 1'b1, 20'h10066, 3'd3, 1'b1, 1'b1, 1'b1);
        flush = 1'b1;
        chk_q("fr_q", 19'h00030, 8'h11);
        step();
        tlb_r_valid = 1'b0;
        flush = 1'b0;
        chk_pt("fr_miss", 1'b1, 1'b0, NO_EX, 20'h0, 1'b0);
        step();
        chk_q("fr_q2", 19'h00030, 8'h11);
        step();

        // Asynchronous reset mid-QUERY drops the query without a clock edge
        resetn = 1'b0;
        push("async_rst", 1'b0, 1'b0, NO_EX, 1'b0, 1'b1, 20'h0, 1'b0, 1'b1, '0, '0);
        step();
        resetn = 1'b1;
        chk_pt("after_rst", 1'b1, 1'b0, NO_EX, 20'h0, 1'b0);
        step();
        req(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        if (sbq.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain pending=%0d want=0", sbq.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
